// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit.
// Optional ADDI support is enabled by defining MIPS_CTRL_ADDI_EN.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alucont_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_JEX     = 4'd9
`ifdef MIPS_CTRL_ADDI_EN
    ,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11
`endif
  } ctrl_state_t;

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's ALU request plus funct to ALUcont.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  aluop_t      i_aluop,
  input  logic [5:0]  i_funct,
  output alucont_t    o_alucont
);

  // Unrecognised funct codes fall back to ADD so the write-back still happens.
  always_comb begin
    o_alucont = ALU_ADD;
    case (i_aluop)
      ALUOP_ADD: o_alucont = ALU_ADD;
      ALUOP_SUB: o_alucont = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FUNCT_ADD: o_alucont = ALU_ADD;
          FUNCT_SUB: o_alucont = ALU_SUB;
          FUNCT_AND: o_alucont = ALU_AND;
          FUNCT_OR:  o_alucont = ALU_OR;
          FUNCT_SLT: o_alucont = ALU_SLT;
          default:   o_alucont = ALU_ADD;
        endcase
      end
      default: o_alucont = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with ALU decoder and branch-qualified PC enable.
// Define MIPS_CTRL_ADDI_EN to add the ADDIEX/ADDIWB states for addi.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] ALUcont,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       pcen
);

  ctrl_state_t r_state;
  ctrl_state_t w_next;

  aluop_t      w_aluop;
  alucont_t    w_aluDec;
  logic        w_aluActive;
  logic        w_alusrca;
  logic [1:0]  w_alusrcb;
  logic [1:0]  w_pcsrc;
  logic        w_iord;
  logic        w_irwrite;
  logic        w_memwrite;
  logic        w_regwrite;
  logic        w_regdst;
  logic        w_memtoreg;
  logic        w_pcwrite;
  logic        w_branch;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = S_FETCH;
    w_aluop     = ALUOP_ADD;
    w_aluActive = 1'b0;
    w_alusrca   = 1'b0;
    w_alusrcb   = 2'b00;
    w_pcsrc     = 2'b00;
    w_iord      = 1'b0;
    w_irwrite   = 1'b0;
    w_memwrite  = 1'b0;
    w_regwrite  = 1'b0;
    w_regdst    = 1'b0;
    w_memtoreg  = 1'b0;
    w_pcwrite   = 1'b0;
    w_branch    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_irwrite   = 1'b1;
        w_alusrcb   = 2'b01;
        w_aluActive = 1'b1;
        w_pcwrite   = 1'b1;
        w_next      = S_DECODE;
      end
      S_DECODE: begin
        w_alusrcb   = 2'b11;
        w_aluActive = 1'b1;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTYPEEX;
          OP_BEQ:       w_next = S_BEQEX;
          OP_J:         w_next = S_JEX;
`ifdef MIPS_CTRL_ADDI_EN
          OP_ADDI:      w_next = S_ADDIEX;
`endif
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        w_alusrca   = 1'b1;
        w_alusrcb   = 2'b10;
        w_aluActive = 1'b1;
        w_next      = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_iord = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        w_alusrca   = 1'b1;
        w_aluop     = ALUOP_FUNCT;
        w_aluActive = 1'b1;
        w_next      = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BEQEX: begin
        w_alusrca   = 1'b1;
        w_aluop     = ALUOP_SUB;
        w_aluActive = 1'b1;
        w_pcsrc     = 2'b01;
        w_branch    = 1'b1;
      end
      S_JEX: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
      end
`ifdef MIPS_CTRL_ADDI_EN
      S_ADDIEX: begin
        w_alusrca   = 1'b1;
        w_alusrcb   = 2'b10;
        w_aluActive = 1'b1;
        w_next      = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
      end
`endif
      default: w_next = S_FETCH;
    endcase
  end

  alu_decoder u_aluDecoder (
    .i_aluop   (w_aluop),
    .i_funct   (funct),
    .o_alucont (w_aluDec)
  );

  // Reset silences every output so an aborted instruction cannot write anything.
  assign ALUcont  = (reset || !w_aluActive) ? 3'b000 : w_aluDec;
  assign alusrca  = !reset && w_alusrca;
  assign alusrcb  = reset ? 2'b00 : w_alusrcb;
  assign pcsrc    = reset ? 2'b00 : w_pcsrc;
  assign iord     = !reset && w_iord;
  assign irwrite  = !reset && w_irwrite;
  assign memwrite = !reset && w_memwrite;
  assign regwrite = !reset && w_regwrite;
  assign regdst   = !reset && w_regdst;
  assign memtoreg = !reset && w_memtoreg;
  assign pcen     = !reset && (w_pcwrite || (w_branch && zero));

endmodule
